// File: rtl/cic_integrator_decim.sv
// cic_integrator_decim: cascaded wrap-around integrators followed by a 1-in-R downsampler.
module cic_integrator_decim #(
  parameter int IW     = 8,
  parameter int OW     = 14,
  parameter int STAGES = 3,
  parameter int R      = 4,
  parameter int M      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_data,
  output logic signed [OW-1:0] o_data,
  output logic                 o_ready
);
  localparam int CW = (R > 2) ? $clog2(R) : 1;

  if (OW < IW + STAGES * $clog2(R * M)) begin : g_bad_width
    $error("cic_integrator_decim: OW too narrow for IW, STAGES, R and M");
  end

  logic signed [OW-1:0] acc_q [STAGES];
  logic signed [OW-1:0] acc_d [STAGES];
  logic        [CW-1:0] cnt_q, cnt_d;
  logic signed [OW-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 last;

  // Integrators advance on accepted samples; every R-th sample captures the last stage.
  always_comb begin
    last    = cnt_q == CW'(R - 1);
    cnt_d   = i_ce ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    data_d  = (i_ce && last) ? acc_q[STAGES-1] : data_q;
    ready_d = i_ce && last;
    acc_d[0] = i_ce ? acc_q[0] + {{(OW-IW){i_data[IW-1]}}, i_data} : acc_q[0];
    for (int k = 1; k < STAGES; k++)
      acc_d[k] = i_ce ? acc_q[k] + acc_q[k-1] : acc_q[k];
  end

  // State registers with synchronous reset taking priority over i_ce.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q   <= '{default: '0};
      cnt_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign o_data  = data_q;
  assign o_ready = ready_q;
endmodule
